uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_cfg.sv | 155 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (RX and TX) and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity/framing/break detection
// and a valid/ready output holding register with overrun pulse.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 521,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitpos;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 pbit;
    logic                 perr;
    logic                 ferr;
    logic                 rxs;
    logic                 done;
    logic                 fin_ferr;
    logic                 fin_brk;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (rx_clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

    always_comb begin
        done     = (state == ST_STOP) && (cnt == LAST)
                   && (stop_idx == LAST_STOP);
        fin_ferr = ferr | ~rxs;
        fin_brk  = ~|shift & ~pbit & fin_ferr;
    end

    // Counter restarts at the start-bit midpoint, so LAST lands mid-bit.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bitpos   <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            pbit     <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= ST_START;
                        pbit  <= 1'b0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt == MID) begin
                        cnt    <= '0;
                        bitpos <= '0;
                        state  <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt           <= '0;
                        shift[bitpos] <= rxs;
                        if (bitpos == LAST_BIT) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bitpos <= bitpos + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        pbit  <= rxs;
                        perr  <= ((^shift) ^ rxs) != PAR_MODE;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (!rxs) ferr <= 1'b1;
                        if (stop_idx == LAST_STOP) state <= ST_IDLE;
                        else stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift;
                    parity_err <= perr;
                    frame_err  <= fin_ferr;
                    break_det  <= fin_brk;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) driven
// with directed and random frames against a frame-level model.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct {
        int         u;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rin = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [2:0] v, pe, fe, bk, ov;
    logic [7:0] d0, d1;
    logic [6:0] d2;

    rec_t got[$];
    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ovcnt[3] = '{0, 0, 0};
    int   vcyc[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .rx_clk(clk), .rst(rst), .rx_in(rin[0]), .rx_data(d0),
        .rx_valid(v[0]), .rx_ready(rdy[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .break_det(bk[0]), .overrun(ov[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .rx_clk(clk), .rst(rst), .rx_in(rin[1]), .rx_data(d1),
        .rx_valid(v[1]), .rx_ready(rdy[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .break_det(bk[1]), .overrun(ov[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .rx_clk(clk), .rst(rst), .rx_in(rin[2]), .rx_data(d2),
        .rx_valid(v[2]), .rx_ready(rdy[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .break_det(bk[2]), .overrun(ov[2]));

    function automatic int nbits(input int u);
        return (u == 2) ? 7 : 8;
    endfunction

    function automatic bit has_par(input int u);
        return u == 1;
    endfunction

    function automatic int nstop(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] data_of(input int u);
        case (u)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return {2'b00, d2};
        endcase
    endfunction

    always @(negedge clk) begin
        rec_t r;
        if (!rst) begin
            for (int u = 0; u < 3; u++) begin
                if (v[u]) vcyc[u]++;
                if (ov[u]) ovcnt[u]++;
                if (v[u] && rdy[u]) begin
                    r.u  = u;
                    r.d  = data_of(u);
                    r.pe = pe[u];
                    r.fe = fe[u];
                    r.bk = bk[u];
                    got.push_back(r);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive_bit(input int u, input logic b);
        rin[u] = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Frame-level model: what a correct receiver reports for this frame.
    task automatic send_frame(input int u, input logic [8:0] data,
                              input logic pbit, input bit stop_ok,
                              input bit expect_it);
        rec_t e;
        logic [8:0] dm;
        dm = data & ((9'd1 << nbits(u)) - 9'd1);
        e.u  = u;
        e.d  = dm;
        e.pe = has_par(u) && ((($countones(dm) + int'(pbit)) % 2) != 0);
        e.fe = !stop_ok;
        e.bk = (dm == 0) && (!has_par(u) || !pbit) && !stop_ok;
        if (expect_it) exp_q.push_back(e);
        drive_bit(u, 1'b0);
        for (int i = 0; i < nbits(u); i++) drive_bit(u, dm[i]);
        if (has_par(u)) drive_bit(u, pbit);
        for (int s = 0; s < nstop(u); s++)
            drive_bit(u, (s == 0) ? logic'(stop_ok) : 1'b1);
        rin[u] = 1'b1;
        if (!stop_ok) begin
            drive_bit(u, 1'b1);
            drive_bit(u, 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        rec_t g, e;
        int k = 0;
        while (got.size() < exp_q.size() && k < 400) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            chk({tag, "_unit"}, g.u, e.u);
            chk({tag, "_data"}, g.d, e.d);
            chk({tag, "_perr"}, g.pe, e.pe);
            chk({tag, "_ferr"}, g.fe, e.fe);
            chk({tag, "_brk"}, g.bk, e.bk);
        end
        exp_q.delete();
        got.delete();
    endtask

    initial begin
        int vb;
        int u;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", v, 3'b000);
        chk("rst_data0", d0, 8'h00);
        chk("rst_flags", {pe, fe, bk, ov}, 12'h000);
        @(posedge clk);
        #1 rst = 1'b0;
        drive_bit(0, 1'b1);

        vb = vcyc[0];
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        drain("a5");
        chk("a5_vpulse", vcyc[0] - vb, 1);

        send_frame(1, 9'h007, 1'b0, 1'b1, 1'b1);
        send_frame(1, 9'h007, 1'b1, 1'b1, 1'b1);
        drain("par");

        send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b1);
        send_frame(0, 9'h000, 1'b0, 1'b0, 1'b1);
        drain("ferr");

        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_count", ovcnt[0], 1);
        chk("ovr_valid", v[0], 1'b1);
        chk("ovr_held", d0, 8'h11);
        rdy[0] = 1'b1;
        drain("ovr");

        vb = vcyc[0];
        rin[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rin[0] = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        chk("glitch_valid", vcyc[0] - vb, 0);
        drain("glitch");

        rdy[1] = 1'b0;
        send_frame(1, 9'h0C3, 1'b0, 1'b1, 1'b0);
        chk("hold_valid", v[1], 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rst = 1'b1;
        rin[0] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", v, 3'b000);
        chk("mrst_data", {d0, d1}, 16'h0000);
        chk("mrst_flags", {pe, fe, bk}, 9'h000);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy[1] = 1'b1;
        drive_bit(0, 1'b1);
        send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1);
        drain("mrst");

        send_frame(2, 9'h07F, 1'b0, 1'b1, 1'b1);
        send_frame(2, 9'h001, 1'b0, 1'b1, 1'b1);
        drain("b2b");

        for (int n = 0; n < 30; n++) begin
            u = int'($urandom_range(0, 2));
            send_frame(u, 9'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) != 0), 1'b1);
            repeat ($urandom_range(0, 2)) drive_bit(u, 1'b1);
            drain("rnd");
        end
        chk("ovr_total", ovcnt[0] + ovcnt[1] + ovcnt[2], 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
